// File: rtl/ring_noc_stop.sv
// Ring network stop: buffers local and ring flits in per-input FIFOs, routes each head
// flit by destination ID to loc_out (eject/loopback) or ring_out, with round-robin arbitration.
`timescale 1ns/1ps
module ring_noc_stop #(
  parameter int NODE_ID    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FLIT_W     = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [FLIT_W-1:0] loc_in_data,
  input  logic              loc_in_valid,
  output logic              loc_in_ready,
  input  logic [FLIT_W-1:0] ring_in_data,
  input  logic              ring_in_valid,
  output logic              ring_in_ready,
  output logic [FLIT_W-1:0] loc_out_data,
  output logic              loc_out_valid,
  input  logic              loc_out_ready,
  output logic [FLIT_W-1:0] ring_out_data,
  output logic              ring_out_valid,
  input  logic              ring_out_ready,
  output logic [15:0]       eject_cnt,
  output logic [15:0]       fwd_cnt
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [5:0] NODE_DEST = 6'(NODE_ID);

  // Input index 0 = ring FIFO (RQ), 1 = local FIFO (LQ); output index 0 = loc_out, 1 = ring_out.
  logic [FLIT_W-1:0] in_data  [2];
  logic [FLIT_W-1:0] head     [2];
  logic [FLIT_W-1:0] out_data [2];
  logic [15:0]       xfer_cnt [2];
  logic [1:0]        in_valid, in_ready, nonempty, is_local, pop;
  logic [1:0]        out_ready, out_valid, gnt_rq, gnt_lq;

  assign in_data[0]   = ring_in_data;
  assign in_data[1]   = loc_in_data;
  assign in_valid     = {loc_in_valid, ring_in_valid};
  assign ring_in_ready = in_ready[0];
  assign loc_in_ready  = in_ready[1];
  assign out_ready    = {ring_out_ready, loc_out_ready};
  assign pop[0]       = |gnt_rq;
  assign pop[1]       = |gnt_lq;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [FLIT_W-1:0] mem [FIFO_DEPTH];
      logic [AW-1:0]     rd_ptr_reg, wr_ptr_reg;
      logic [CW-1:0]     count_reg, count_next;
      logic              ready_reg;
      logic              push;

      assign push       = in_valid[gi] && ready_reg;
      assign count_next = count_reg + CW'(push) - CW'(pop[gi]);

      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
          ready_reg  <= 1'b0;
        end else begin
          if (push)    wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
          count_reg <= count_next;
          ready_reg <= (count_next < CW'(FIFO_DEPTH));
        end
      end

      // Storage needs no reset: the count alone decides what is valid.
      always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr_reg] <= in_data[gi];
      end

      assign head[gi]     = mem[rd_ptr_reg];
      assign nonempty[gi] = (count_reg != '0);
      assign is_local[gi] = (head[gi][FLIT_W-1 -: 6] == NODE_DEST);
      assign in_ready[gi] = ready_reg;
    end

    for (gi = 0; gi < 2; gi++) begin : g_out
      localparam logic WANT_LOCAL = (gi == 0);
      logic              valid_reg, ptr_reg;
      logic [FLIT_W-1:0] data_reg;
      logic [15:0]       cnt_reg;
      logic              can_load, req_r, req_l;

      assign can_load = !valid_reg || out_ready[gi];
      assign req_r    = nonempty[0] && (is_local[0] == WANT_LOCAL);
      assign req_l    = nonempty[1] && (is_local[1] == WANT_LOCAL);
      // ptr_reg 0 favours the ring FIFO, 1 favours the local FIFO.
      assign gnt_rq[gi] = can_load && req_r && (!req_l || !ptr_reg);
      assign gnt_lq[gi] = can_load && req_l && (!req_r || ptr_reg);

      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
          ptr_reg   <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          if (gnt_rq[gi] || gnt_lq[gi]) begin
            valid_reg <= 1'b1;
            data_reg  <= gnt_lq[gi] ? head[1] : head[0];
          end else if (out_ready[gi]) begin
            valid_reg <= 1'b0;
          end
          if (can_load && req_r && req_l) ptr_reg <= ~ptr_reg;
          if (valid_reg && out_ready[gi]) cnt_reg <= cnt_reg + 16'd1;
        end
      end

      assign out_valid[gi] = valid_reg;
      assign out_data[gi]  = data_reg;
      assign xfer_cnt[gi]  = cnt_reg;
    end
  endgenerate

  assign loc_out_valid  = out_valid[0];
  assign loc_out_data   = out_data[0];
  assign ring_out_valid = out_valid[1];
  assign ring_out_data  = out_data[1];
  assign eject_cnt      = xfer_cnt[0];
  assign fwd_cnt        = xfer_cnt[1];
endmodule

// File: tb/tb_ring_noc_stop.sv
// Directed self-checking bench for ring_noc_stop: table of single-shot routing vectors
// followed by hand sequences for contention, back-pressure, counter wrap and mid-run reset.
`timescale 1ns/1ps
module tb_ring_noc_stop;
  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [15:0] loc_in_data, ring_in_data;
  logic        loc_in_valid, ring_in_valid;
  logic        loc_in_ready, ring_in_ready;
  logic [15:0] loc_out_data, ring_out_data;
  logic        loc_out_valid, ring_out_valid;
  logic        loc_out_ready, ring_out_ready;
  logic [15:0] eject_cnt, fwd_cnt;

  ring_noc_stop #(.NODE_ID(8), .FIFO_DEPTH(4), .FLIT_W(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .loc_in_data(loc_in_data), .loc_in_valid(loc_in_valid), .loc_in_ready(loc_in_ready),
    .ring_in_data(ring_in_data), .ring_in_valid(ring_in_valid), .ring_in_ready(ring_in_ready),
    .loc_out_data(loc_out_data), .loc_out_valid(loc_out_valid), .loc_out_ready(loc_out_ready),
    .ring_out_data(ring_out_data), .ring_out_valid(ring_out_valid), .ring_out_ready(ring_out_ready),
    .eject_cnt(eject_cnt), .fwd_cnt(fwd_cnt)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rv;  logic [15:0] rd;
    logic        lv;  logic [15:0] ld;
    logic        elv; logic [15:0] eld;
    logic        erv; logic [15:0] erd;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];
  logic [15:0] cont_exp [4];
  int exp_ej = 0;
  int exp_fw = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, guard, left;
    logic acc;

    vecs[0] = '{1'b1, 16'h2123, 1'b0, 16'h0000, 1'b1, 16'h2123, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 16'h2523, 1'b0, 16'h0000, 1'b1, 16'h2523};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 16'h2001, 1'b1, 16'h2001, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 16'h2400, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h2400};
    vecs[4] = '{1'b1, 16'h2055, 1'b1, 16'h2466, 1'b1, 16'h2055, 1'b1, 16'h2466};
    vecs[5] = '{1'b1, 16'hFC01, 1'b1, 16'h23FF, 1'b1, 16'h23FF, 1'b1, 16'hFC01};
    vecs[6] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000};
    cont_exp[0] = 16'h2011; cont_exp[1] = 16'h2021;
    cont_exp[2] = 16'h2012; cont_exp[3] = 16'h2022;

    loc_in_data = '0; ring_in_data = '0; loc_in_valid = 0; ring_in_valid = 0;
    loc_out_ready = 1; ring_out_ready = 1;
    ARESETn = 1'b1;
    #2 ARESETn = 1'b0;

    // Reset held for 3 cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      check("rst loc_in_ready", loc_in_ready, 0);
      check("rst ring_in_ready", ring_in_ready, 0);
      check("rst valids", {loc_out_valid, ring_out_valid}, 0);
      check("rst datas", {loc_out_data, ring_out_data}, 0);
      check("rst counters", {eject_cnt, fwd_cnt}, 0);
    end
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("readyup loc", loc_in_ready, 1);
    check("readyup ring", ring_in_ready, 1);
    $display("[TB] reset released, readies loc=%0b ring=%0b", loc_in_ready, ring_in_ready);

    // Table-driven single-shot routing vectors
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rv) check("vec ring_in_ready", ring_in_ready, 1);
      if (vecs[i].lv) check("vec loc_in_ready", loc_in_ready, 1);
      ring_in_valid = vecs[i].rv; ring_in_data = vecs[i].rd;
      loc_in_valid  = vecs[i].lv; loc_in_data  = vecs[i].ld;
      @(negedge ACLK);
      ring_in_valid = 0; loc_in_valid = 0;
      check("vec early valids", {loc_out_valid, ring_out_valid}, 0);
      @(negedge ACLK);
      check("vec loc_out_valid", loc_out_valid, vecs[i].elv);
      check("vec ring_out_valid", ring_out_valid, vecs[i].erv);
      if (vecs[i].elv) check("vec loc_out_data", loc_out_data, vecs[i].eld);
      if (vecs[i].erv) check("vec ring_out_data", ring_out_data, vecs[i].erd);
      $display("[TB] vec %0d ring_in=%h/%0b loc_in=%h/%0b -> loc_out=%h/%0b ring_out=%h/%0b",
               i, vecs[i].rd, vecs[i].rv, vecs[i].ld, vecs[i].lv,
               loc_out_data, loc_out_valid, ring_out_data, ring_out_valid);
      exp_ej += int'(vecs[i].elv);
      exp_fw += int'(vecs[i].erv);
      @(negedge ACLK);
      check("vec eject_cnt", eject_cnt, exp_ej);
      check("vec fwd_cnt", fwd_cnt, exp_fw);
    end

    // Contention on loc_out: R0,L0,R1,L1 back-to-back
    ring_in_valid = 1; ring_in_data = 16'h2011; loc_in_valid = 1; loc_in_data = 16'h2021;
    @(negedge ACLK);
    ring_in_data = 16'h2012; loc_in_data = 16'h2022;
    @(negedge ACLK);
    ring_in_valid = 0; loc_in_valid = 0;
    for (int j = 0; j < 4; j++) begin
      check("cont valid", loc_out_valid, 1);
      check("cont order", loc_out_data, cont_exp[j]);
      $display("[TB] contention slot %0d loc_out=%h", j, loc_out_data);
      @(negedge ACLK);
    end
    exp_ej += 4;
    check("cont eject_cnt", eject_cnt, exp_ej);
    check("cont ring idle", ring_out_valid, 0);

    // Back-pressure on ring_out fills LQ
    ring_out_ready = 0;
    for (int j = 0; j < 5; j++) begin
      check("bp ready before push", loc_in_ready, 1);
      loc_in_valid = 1; loc_in_data = 16'h2400 + 16'(j);
      @(negedge ACLK);
    end
    loc_in_data = 16'h2405;
    check("bp full ready", loc_in_ready, 0);
    check("bp stage data", ring_out_data, 16'h2400);
    repeat (2) @(negedge ACLK);
    check("bp still full", loc_in_ready, 0);
    check("bp data held", {15'd0, ring_out_valid, ring_out_data}, {15'd0, 1'b1, 16'h2400});
    ring_out_ready = 1;
    n = 0; guard = 0;
    while (n < 6 && guard < 20) begin
      acc = loc_in_valid && loc_in_ready;
      if (ring_out_valid && ring_out_ready) begin
        check("bp exit order", ring_out_data, 16'h2400 + 16'(n));
        $display("[TB] bp exit %0d ring_out=%h", n, ring_out_data);
        n++;
      end
      @(negedge ACLK);
      guard++;
      if (acc) loc_in_valid = 0;
    end
    check("bp exit count", n, 6);
    exp_fw += 6;
    check("bp fwd_cnt", fwd_cnt, exp_fw);
    check("bp ready back", loc_in_ready, 1);

    // Stream forwarded flits until fwd_cnt reaches 0xFFFF, then wrap
    left = 32'hFFFF - exp_fw;
    guard = 0;
    loc_in_data = 16'h2400;
    loc_in_valid = 1;
    while (left > 0 && guard < 70000) begin
      if (loc_in_ready) left--;
      @(negedge ACLK);
      guard++;
    end
    loc_in_valid = 0;
    check("wrap pushes done", left, 0);
    repeat (3) @(negedge ACLK);
    check("wrap at max", fwd_cnt, 16'hFFFF);
    $display("[TB] streamed to fwd_cnt=%h", fwd_cnt);
    loc_in_valid = 1; loc_in_data = 16'h2401;
    @(negedge ACLK);
    loc_in_valid = 0;
    repeat (2) @(negedge ACLK);
    check("wrap to zero", fwd_cnt, 16'h0000);
    $display("[TB] one more forward, fwd_cnt=%h", fwd_cnt);

    // Reset with flits queued: everything is discarded
    ring_out_ready = 0; loc_out_ready = 0;
    loc_in_valid = 1; ring_in_valid = 1;
    loc_in_data = 16'h2410; ring_in_data = 16'h2031;
    @(negedge ACLK);
    loc_in_data = 16'h2411; ring_in_data = 16'h2032;
    @(negedge ACLK);
    loc_in_valid = 0; ring_in_valid = 0;
    @(negedge ACLK);
    check("mid pre-reset valids", {loc_out_valid, ring_out_valid}, 2'b11);
    ARESETn = 0;
    #1;
    check("mid async valids", {loc_out_valid, ring_out_valid}, 0);
    check("mid async datas", {loc_out_data, ring_out_data}, 0);
    check("mid async counters", {eject_cnt, fwd_cnt}, 0);
    check("mid async readies", {loc_in_ready, ring_in_ready}, 0);
    @(negedge ACLK);
    ARESETn = 1; loc_out_ready = 1; ring_out_ready = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge ACLK);
      check("mid post-reset idle", {loc_out_valid, ring_out_valid}, 0);
    end
    $display("[TB] mid-run reset: outputs idle after release");
    ring_in_valid = 1; ring_in_data = 16'h2077;
    @(negedge ACLK);
    ring_in_valid = 0;
    @(negedge ACLK);
    check("recover valid", loc_out_valid, 1);
    check("recover data", loc_out_data, 16'h2077);
    @(negedge ACLK);
    check("recover eject_cnt", eject_cnt, 1);
    $display("[TB] recovery flit loc_out eject_cnt=%0d", eject_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
